// File: rtl/alu_seq_pkg.sv
// Shared types for the 4-bit datapath microsequencer: states, SHIFTER codes,
// shift requests, the latched command and the decoded control vector.
package alu_seq_pkg;

    localparam int DATAWIDTH  = 4;
    localparam int INDEXWIDTH = 2;
    localparam int OPWIDTH    = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_EXEC,
        S_SHIFT,
        S_WB
    } state_t;

    typedef enum logic [1:0] {
        ST_HOLD = 2'b00,
        ST_LOAD = 2'b01,
        ST_SHL  = 2'b10,
        ST_SHR  = 2'b11
    } st_op_t;

    typedef enum logic [1:0] {
        SH_NONE  = 2'b00,
        SH_LEFT  = 2'b01,
        SH_RIGHT = 2'b10,
        SH_ROTL  = 2'b11
    } shift_req_t;

    typedef struct packed {
        logic [OPWIDTH-1:0]    op;
        shift_req_t            shift;
        logic [INDEXWIDTH-1:0] dst;
        logic [INDEXWIDTH-1:0] src;
        logic [DATAWIDTH-1:0]  imm;
        logic                  use_imm;
        logic                  no_wb;
    } cmd_t;

    typedef struct packed {
        logic                  ace;
        logic                  grsce;
        logic                  pswce;
        st_op_t                st_op;
        logic                  dataoe;
        logic                  grsoe;
        logic                  soe;
        logic [INDEXWIDTH-1:0] index;
        logic                  done;
    } ctrl_t;

    function automatic state_t next_state(
        input state_t     s,
        input shift_req_t sh,
        input logic       no_wb,
        input logic       start
    );
        state_t n;
        n = S_IDLE;
        unique case (s)
            S_IDLE:   n = start ? S_LOAD_A : S_IDLE;
            S_LOAD_A: n = S_EXEC;
            S_EXEC:   n = (sh != SH_NONE) ? S_SHIFT : (no_wb ? S_IDLE : S_WB);
            S_SHIFT:  n = no_wb ? S_IDLE : S_WB;
            S_WB:     n = S_IDLE;
            default:  n = S_IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational state + latched command to datapath control-vector decoder.
// At most one of DATAOE/GRSOE/SOE is ever set.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  state_t                state,
    input  shift_req_t            shift,
    input  logic [INDEXWIDTH-1:0] dst,
    input  logic [INDEXWIDTH-1:0] src,
    input  logic                  use_imm,
    input  logic                  no_wb,
    output ctrl_t                 ctrl
);

    always_comb begin
        // NOTE: every field gets a default before the case, so no path can infer a latch.
        ctrl       = '0;
        ctrl.st_op = ST_HOLD;
        unique case (state)
            S_IDLE: ;
            S_LOAD_A: begin
                ctrl.grsoe = 1'b1;
                ctrl.index = dst;
                ctrl.ace   = 1'b1;
            end
            S_EXEC: begin
                if (use_imm) begin
                    ctrl.dataoe = 1'b1;
                end else begin
                    ctrl.grsoe = 1'b1;
                    ctrl.index = src;
                end
                ctrl.st_op = ST_LOAD;
                ctrl.pswce = 1'b1;
                ctrl.done  = (shift == SH_NONE) && no_wb;
            end
            S_SHIFT: begin
                // Rotate-left relies on the SHIFTER's circular mode, so it is a plain left step here.
                ctrl.st_op = (shift == SH_RIGHT) ? ST_SHR : ST_SHL;
                ctrl.done  = no_wb;
            end
            S_WB: begin
                ctrl.soe   = 1'b1;
                ctrl.index = dst;
                ctrl.grsce = 1'b1;
                ctrl.done  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus_exclusive: assert ((int'(ctrl.dataoe) + int'(ctrl.grsoe) + int'(ctrl.soe)) <= 1);
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Microsequencer driving the A/GRS/ALU/SHIFTER/PSW datapath and its shared BUS.
// Optional ALU_SEQ_STEP_EN adds a STEP input for single-stepping on a board.
module alu_seq_ctrl
    import alu_seq_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic [OPWIDTH-1:0]    OP,
    input  logic [1:0]            SHIFT,
    input  logic [INDEXWIDTH-1:0] DST,
    input  logic [INDEXWIDTH-1:0] SRC,
    input  logic [DATAWIDTH-1:0]  IMM,
    input  logic                  USE_IMM,
    input  logic                  NO_WB,
`ifdef ALU_SEQ_STEP_EN
    input  logic                  STEP,
`endif
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ACE,
    output logic                  GRSCE,
    output logic                  PSWCE,
    output logic [1:0]            ST_OP,
    output logic [OPWIDTH-1:0]    ALU_OP,
    output logic                  DATAOE,
    output logic                  GRSOE,
    output logic                  SOE,
    output logic [INDEXWIDTH-1:0] INDEX,
    output logic [DATAWIDTH-1:0]  DATA
);

    state_t state;
    cmd_t   cmd;
    ctrl_t  dec;
    logic   advance;

`ifdef ALU_SEQ_STEP_EN
    assign advance = STEP;
`else
    assign advance = 1'b1;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            // NOTE: the command latch is reset too, so ALU_OP and DATA come up 0.
            state <= S_IDLE;
            cmd   <= '0;
        end else if (advance) begin
            // NOTE: non-blocking so the latch and next state both see this cycle's values.
            if (state == S_IDLE && START) begin
                cmd <= '{op: OP, shift: shift_req_t'(SHIFT), dst: DST, src: SRC,
                         imm: IMM, use_imm: USE_IMM, no_wb: NO_WB};
            end
            state <= next_state(state, cmd.shift, cmd.no_wb, START);
        end
    end

    alu_seq_decode u_decode (
        .state   (state),
        .shift   (cmd.shift),
        .dst     (cmd.dst),
        .src     (cmd.src),
        .use_imm (cmd.use_imm),
        .no_wb   (cmd.no_wb),
        .ctrl    (dec)
    );

    // Enables are gated by advance so a held step never writes the datapath.
    assign ACE    = dec.ace    & advance;
    assign GRSCE  = dec.grsce  & advance;
    assign PSWCE  = dec.pswce  & advance;
    assign DATAOE = dec.dataoe & advance;
    assign GRSOE  = dec.grsoe  & advance;
    assign SOE    = dec.soe    & advance;
    assign DONE   = dec.done   & advance;
    assign ST_OP  = advance ? dec.st_op : ST_HOLD;
    assign INDEX  = dec.index;
    assign BUSY   = (state != S_IDLE);
    assign ALU_OP = cmd.op;
    assign DATA   = cmd.imm;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural model of the 4-bit datapath
// (A, GRS, ALU, SHIFTER, PSW, BUS) driven by the sequencer's control outputs.
module tb_alu_seq_ctrl;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;

    logic       CLK = 1'b0;
    logic       RESET_N = 1'b0;
    logic       START = 1'b0;
    logic [3:0] OP = 4'h0;
    logic [1:0] SHIFT = 2'b00;
    logic [1:0] DST = 2'b00;
    logic [1:0] SRC = 2'b00;
    logic [3:0] IMM = 4'h0;
    logic       USE_IMM = 1'b0;
    logic       NO_WB = 1'b0;
    logic       STEP = 1'b1;

    logic       BUSY, DONE, ACE, GRSCE, PSWCE, DATAOE, GRSOE, SOE;
    logic [1:0] ST_OP, INDEX;
    logic [3:0] ALU_OP, DATA;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    alu_seq_ctrl dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .START   (START),
        .OP      (OP),
        .SHIFT   (SHIFT),
        .DST     (DST),
        .SRC     (SRC),
        .IMM     (IMM),
        .USE_IMM (USE_IMM),
        .NO_WB   (NO_WB),
`ifdef ALU_SEQ_STEP_EN
        .STEP    (STEP),
`endif
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ACE     (ACE),
        .GRSCE   (GRSCE),
        .PSWCE   (PSWCE),
        .ST_OP   (ST_OP),
        .ALU_OP  (ALU_OP),
        .DATAOE  (DATAOE),
        .GRSOE   (GRSOE),
        .SOE     (SOE),
        .INDEX   (INDEX),
        .DATA    (DATA)
    );

    // ---------------- datapath model ----------------
    logic [3:0] grs [4];
    logic [3:0] a_reg = 4'h0;
    logic [3:0] s_reg = 4'h0;
    logic       psw_z = 1'b0;
    logic       psw_c = 1'b0;
    logic [3:0] snap_bus = 4'h0;
    logic [3:0] snap_op = 4'h0;
    logic [1:0] snap_st = 2'b00;
    logic [1:0] snap_idx = 2'b00;
    logic       snap_ace = 1'b0, snap_grsce = 1'b0, snap_pswce = 1'b0;
    logic       pre_en = 1'b0;
    logic [1:0] pre_idx = 2'b00;
    logic [3:0] pre_val = 4'h0;
    logic [4:0] f_v;

    function automatic logic [4:0] alu_f(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
        if (op == OP_SUB) return {(a < b), 4'(a - b)};
        return {1'b0, a} + {1'b0, b};
    endfunction

    assign f_v = alu_f(snap_op, a_reg, snap_bus);

    always @(negedge CLK) begin
        snap_bus   <= DATAOE ? DATA : (GRSOE ? grs[INDEX] : (SOE ? s_reg : 4'h0));
        snap_op    <= ALU_OP;
        snap_st    <= ST_OP;
        snap_idx   <= INDEX;
        snap_ace   <= ACE;
        snap_grsce <= GRSCE;
        snap_pswce <= PSWCE;
    end

    always @(posedge CLK) begin
        if (pre_en) grs[pre_idx] <= pre_val;
        if (RESET_N) begin
            if (snap_ace) a_reg <= snap_bus;
            if (snap_pswce) begin
                psw_c <= f_v[4];
                psw_z <= (f_v[3:0] == 4'h0);
            end
            case (snap_st)
                2'b01:   s_reg <= f_v[3:0];
                2'b10:   s_reg <= {s_reg[2:0], 1'b0};
                2'b11:   s_reg <= {1'b0, s_reg[3:1]};
                default: ;
            endcase
            if (snap_grsce) grs[snap_idx] <= snap_bus;
        end
    end

    // ---------------- per-instruction observations ----------------
    int         psw_cnt, grsce_cnt, dataoe_cnt, dataoe_cyc, bus_viol;
    logic [1:0] st_hist [21];

    task automatic preload(input logic [1:0] idx, input logic [3:0] val);
        @(posedge CLK); #1;
        pre_en = 1'b1; pre_idx = idx; pre_val = val;
        @(posedge CLK); #1;
        pre_en = 1'b0;
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [1:0] sh, input logic [1:0] dst,
                             input logic [1:0] src, input logic [3:0] imm, input logic ui,
                             input logic nw, output int lat);
        @(posedge CLK); #1;
        OP = op; SHIFT = sh; DST = dst; SRC = src; IMM = imm; USE_IMM = ui; NO_WB = nw;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        // Scramble the command inputs: the latched copy must be used from here on.
        OP = 4'hE; SHIFT = ~sh; DST = ~dst; SRC = ~src; IMM = ~imm; USE_IMM = ~ui; NO_WB = ~nw;
        lat = 0; psw_cnt = 0; grsce_cnt = 0; dataoe_cnt = 0; dataoe_cyc = 0; bus_viol = 0;
        for (int i = 0; i < 21; i++) st_hist[i] = 2'b00;
        for (int i = 1; i <= 20; i++) begin
            @(negedge CLK);
            if ((int'(DATAOE) + int'(GRSOE) + int'(SOE)) > 1) bus_viol++;
            if (PSWCE) psw_cnt++;
            if (GRSCE) grsce_cnt++;
            if (DATAOE) begin dataoe_cnt++; dataoe_cyc = i; end
            st_hist[i] = ST_OP;
            if (DONE) begin lat = i; break; end
        end
        checks++;
        if (lat == 0) begin failures++; $display("FAIL done_timeout got=no DONE exp=DONE within 20 cycles"); end
        @(posedge CLK); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        RESET_N = 1'b0;
        #12;
        checks++;
        if ({BUSY, DONE, ACE, GRSCE, PSWCE, DATAOE, GRSOE, SOE} !== 8'h00) begin
            failures++; $display("FAIL reset_flags got=%b exp=00000000", {BUSY, DONE, ACE, GRSCE, PSWCE, DATAOE, GRSOE, SOE});
        end
        checks++;
        if ({ST_OP, ALU_OP, INDEX, DATA} !== 12'h000) begin
            failures++; $display("FAIL reset_fields got=%h exp=000", {ST_OP, ALU_OP, INDEX, DATA});
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (BUSY !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", BUSY); end
    endtask

    task automatic test_add_reg;
        int lat;
        preload(2'd1, 4'd3);
        preload(2'd2, 4'd4);
        run_instr(OP_ADD, 2'b00, 2'd1, 2'd2, 4'h0, 1'b0, 1'b0, lat);
        checks++; if (lat != 3) begin failures++; $display("FAIL add_latency got=%0d exp=3", lat); end
        checks++; if (grs[1] !== 4'd7) begin failures++; $display("FAIL add_result got=%h exp=7", grs[1]); end
        checks++; if (psw_cnt != 1) begin failures++; $display("FAIL add_psw_updates got=%0d exp=1", psw_cnt); end
        checks++; if (grsce_cnt != 1) begin failures++; $display("FAIL add_grsce got=%0d exp=1", grsce_cnt); end
        checks++; if (bus_viol != 0) begin failures++; $display("FAIL add_bus_excl got=%0d exp=0", bus_viol); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL add_busy_after got=%b exp=0", BUSY); end
    endtask

    task automatic test_imm_sub;
        int lat;
        preload(2'd0, 4'h2);
        run_instr(OP_SUB, 2'b00, 2'd0, 2'd3, 4'hF, 1'b1, 1'b0, lat);
        checks++; if (lat != 3) begin failures++; $display("FAIL imm_latency got=%0d exp=3", lat); end
        checks++; if (dataoe_cnt != 1 || dataoe_cyc != 2) begin
            failures++; $display("FAIL imm_dataoe got=%0d@%0d exp=1@2", dataoe_cnt, dataoe_cyc);
        end
        checks++; if (grs[0] !== 4'h3) begin failures++; $display("FAIL imm_result got=%h exp=3", grs[0]); end
        checks++; if (psw_c !== 1'b1) begin failures++; $display("FAIL imm_borrow got=%b exp=1", psw_c); end
        checks++; if (ALU_OP !== OP_SUB || DATA !== 4'hF) begin
            failures++; $display("FAIL imm_latched got=%h/%h exp=1/f", ALU_OP, DATA);
        end
        checks++; if (bus_viol != 0) begin failures++; $display("FAIL imm_bus_excl got=%0d exp=0", bus_viol); end
    endtask

    task automatic test_compare;
        int lat;
        preload(2'd2, 4'd5);
        preload(2'd3, 4'd5);
        run_instr(OP_SUB, 2'b00, 2'd2, 2'd3, 4'h0, 1'b0, 1'b1, lat);
        checks++; if (lat != 2) begin failures++; $display("FAIL cmp_latency got=%0d exp=2", lat); end
        checks++; if (grsce_cnt != 0) begin failures++; $display("FAIL cmp_grsce got=%0d exp=0", grsce_cnt); end
        checks++; if (psw_z !== 1'b1) begin failures++; $display("FAIL cmp_zero got=%b exp=1", psw_z); end
        checks++; if (grs[2] !== 4'd5) begin failures++; $display("FAIL cmp_grs_kept got=%h exp=5", grs[2]); end
    endtask

    task automatic test_shift;
        int lat;
        preload(2'd1, 4'd2);
        preload(2'd2, 4'd3);
        run_instr(OP_ADD, 2'b01, 2'd1, 2'd2, 4'h0, 1'b0, 1'b0, lat);
        checks++; if (lat != 4) begin failures++; $display("FAIL shl_latency got=%0d exp=4", lat); end
        checks++; if ({st_hist[2], st_hist[3], st_hist[4]} !== 6'b01_10_00) begin
            failures++; $display("FAIL shl_st_seq got=%b exp=011000", {st_hist[2], st_hist[3], st_hist[4]});
        end
        checks++; if (grs[1] !== 4'hA) begin failures++; $display("FAIL shl_result got=%h exp=a", grs[1]); end
        checks++; if (psw_cnt != 1) begin failures++; $display("FAIL shl_psw_updates got=%0d exp=1", psw_cnt); end
        preload(2'd0, 4'd4);
        preload(2'd3, 4'd4);
        run_instr(OP_ADD, 2'b10, 2'd0, 2'd3, 4'h0, 1'b0, 1'b0, lat);
        checks++; if (st_hist[3] !== 2'b11) begin failures++; $display("FAIL shr_st got=%b exp=11", st_hist[3]); end
        checks++; if (grs[0] !== 4'h4) begin failures++; $display("FAIL shr_result got=%h exp=4", grs[0]); end
    endtask

    task automatic test_reset_mid;
        int   lat;
        logic z0, c0;
        preload(2'd1, 4'd6);
        preload(2'd2, 4'd1);
        @(posedge CLK); #1;
        OP = OP_ADD; SHIFT = 2'b00; DST = 2'd1; SRC = 2'd2; USE_IMM = 1'b0; NO_WB = 1'b0;
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        z0 = psw_z; c0 = psw_c;
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (PSWCE !== 1'b1) begin failures++; $display("FAIL mid_in_exec got=%b exp=1", PSWCE); end
        #2;
        RESET_N = 1'b0;
        #1;
        checks++;
        if ({BUSY, DONE, ACE, GRSCE, PSWCE, DATAOE, GRSOE, SOE, ST_OP, ALU_OP, INDEX, DATA} !== 20'h0) begin
            failures++; $display("FAIL mid_async_clear got=%h exp=00000",
                                 {BUSY, DONE, ACE, GRSCE, PSWCE, DATAOE, GRSOE, SOE, ST_OP, ALU_OP, INDEX, DATA});
        end
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        checks++; if (grs[1] !== 4'd6 || psw_z !== z0 || psw_c !== c0) begin
            failures++; $display("FAIL mid_no_write got=%h/%b%b exp=6/%b%b", grs[1], psw_z, psw_c, z0, c0);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        run_instr(OP_ADD, 2'b00, 2'd1, 2'd2, 4'h0, 1'b0, 1'b0, lat);
        checks++; if (lat != 3 || grs[1] !== 4'd7) begin
            failures++; $display("FAIL mid_restart got=%0d/%h exp=3/7", lat, grs[1]);
        end
    endtask

    task automatic test_back_to_back;
        int   t [2];
        int   k = 0;
        logic busy_at_done = 1'b0;
        preload(2'd3, 4'd1);
        @(posedge CLK); #1;
        OP = OP_ADD; SHIFT = 2'b00; DST = 2'd3; SRC = 2'd3; USE_IMM = 1'b0; NO_WB = 1'b0;
        START = 1'b1;
        t[0] = 0; t[1] = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge CLK);
            if (DONE) begin
                t[k] = n;
                if (k == 0) busy_at_done = BUSY;
                k++;
                if (k == 2) begin START = 1'b0; break; end
            end
        end
        START = 1'b0;
        @(posedge CLK); #1;
        checks++; if (k != 2 || t[0] != 3 || t[1] != 7) begin
            failures++; $display("FAIL b2b_done_cycles got=%0d:%0d,%0d exp=2:3,7", k, t[0], t[1]);
        end
        checks++; if (busy_at_done !== 1'b1) begin failures++; $display("FAIL b2b_busy_in_done got=%b exp=1", busy_at_done); end
        checks++; if (grs[3] !== 4'd4) begin failures++; $display("FAIL b2b_result got=%h exp=4", grs[3]); end
    endtask

`ifdef ALU_SEQ_STEP_EN
    task automatic test_step;
        int   bad = 0;
        int   done_on = 0;
        logic ace_p1 = 1'b0;
        preload(2'd1, 4'd3);
        preload(2'd2, 4'd4);
        @(posedge CLK); #1;
        OP = OP_ADD; SHIFT = 2'b00; DST = 2'd1; SRC = 2'd2; USE_IMM = 1'b0; NO_WB = 1'b0;
        START = 1'b1; STEP = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; STEP = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if ({ACE, GRSCE, PSWCE, DATAOE, GRSOE, SOE, DONE} !== 7'h0 || ST_OP !== 2'b00 || BUSY !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL step_frozen got=%0d exp=0", bad); end
        for (int p = 1; p <= 3; p++) begin
            @(posedge CLK); #1;
            STEP = 1'b1;
            @(negedge CLK);
            if (p == 1) ace_p1 = ACE;
            if (DONE && done_on == 0) done_on = p;
            @(posedge CLK); #1;
            STEP = 1'b0;
        end
        STEP = 1'b1;
        checks++; if (ace_p1 !== 1'b1) begin failures++; $display("FAIL step_load_a got=%b exp=1", ace_p1); end
        checks++; if (done_on != 3) begin failures++; $display("FAIL step_done_pulse got=%0d exp=3", done_on); end
        checks++; if (grs[1] !== 4'd7) begin failures++; $display("FAIL step_result got=%h exp=7", grs[1]); end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add_reg();
        test_imm_sub();
        test_compare();
        test_shift();
        test_reset_mid();
        test_back_to_back();
`ifdef ALU_SEQ_STEP_EN
        test_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
